// File: rtl/mod_port_pkg.sv
// Shared types and constants for the modulo-12 up/down counter.
package mod_port_pkg;

   localparam int unsigned COUNT_W   = 4;
   localparam int unsigned COUNT_MOD = 12;

   typedef logic [COUNT_W-1:0] count_t;

   // Out-of-range load values collapse to zero so they are never stored.
   function automatic count_t sanitize_load(input count_t value);
      return (32'(value) >= COUNT_MOD) ? '0 : value;
   endfunction

endpackage

// File: rtl/mod_port_if.sv
// Counter bus: write side drives load/updown/d_in, read side observes d_out.
interface mod_port_if;
   import mod_port_pkg::*;

   logic   load;
   logic   updown;
   count_t d_in;
   count_t d_out;

   modport master (output load, output updown, output d_in, input d_out);
   modport slave  (input load, input updown, input d_in, output d_out);

endinterface

// File: rtl/mod_port_next.sv
// Combinational next-count logic: load has priority, otherwise wrap-aware up/down step.
module mod_port_next
   import mod_port_pkg::*;
(
   input  logic   load,
   input  logic   updown,
   input  count_t d_in,
   input  count_t count,
   output count_t next_c
);

   localparam count_t MAX_COUNT = count_t'(COUNT_MOD - 1);

   // Wrap uses explicit compares so values 12..15 are unreachable.
   always_comb begin
      next_c = count;
      if (load) begin
         next_c = sanitize_load(d_in);
      end else if (updown) begin
         next_c = (count == MAX_COUNT) ? '0 : count + count_t'(1);
      end else begin
         next_c = (count == '0) ? MAX_COUNT : count - count_t'(1);
      end
   end

endmodule

// File: rtl/mod_port.sv
// Modulo-12 up/down counter with synchronous load; output driven straight from the count register.
module mod_port
   import mod_port_pkg::*;
(
   input  logic     clock,
   input  logic     rst,
   mod_port_if.slave bus
);

   count_t count_q;
   count_t count_next_c;

   mod_port_next u_next (
      .load   (bus.load),
      .updown (bus.updown),
      .d_in   (bus.d_in),
      .count  (count_q),
      .next_c (count_next_c)
   );

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_next_c;
      end
   end

   assign bus.d_out = count_q;

endmodule

// File: tb/tb_mod_port.sv
// Self-checking bench for mod_port: directed corner cases plus randomized run against a modulo-arithmetic model.
module tb_mod_port;
   import mod_port_pkg::*;

   logic clock = 1'b0;
   logic rst;

   mod_port_if bus ();

   mod_port dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int model    = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_next(input int cur, input bit ld, input bit ud, input int din);
      if (ld)
         return (din >= 12) ? 0 : din;
      else if (ud)
         return (cur + 1) % 12;
      else
         return (cur + 11) % 12;
   endfunction

   task automatic drive(input bit ld, input bit ud, input int din);
      bus.load   = ld;
      bus.updown = ud;
      bus.d_in   = count_t'(din);
   endtask

   // Advance one edge, update the model from the inputs seen at that edge, settle 1 unit.
   task automatic step();
      @(posedge clock);
      if (rst)
         model = ref_next(model, bus.load, bus.updown, int'(bus.d_in));
      else
         model = 0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int up_exp[5];
      int dn_exp[4];
      bit ld;
      bit ud;
      int din;

      up_exp = '{10, 11, 0, 1, 2};
      dn_exp = '{1, 0, 11, 10};

      rst = 1'b0;
      drive(0, 1, 0);
      #2;
      check_eq("reset_state", int'(bus.d_out), 0);

      @(posedge clock);
      #1;
      rst = 1'b1;
      step();
      check_eq("release_first_count", int'(bus.d_out), 1);

      // Asynchronous reset mid-count at 7
      drive(1, 1, 7);
      step();
      check_eq("load7", int'(bus.d_out), 7);
      drive(0, 1, 0);
      #3;
      rst = 1'b0;
      model = 0;
      #1;
      check_eq("rst_async", int'(bus.d_out), 0);
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
         step();
         check_eq("rst_hold", int'(bus.d_out), 0);
      end
      rst = 1'b1;
      drive(0, 1, 0);
      step();
      check_eq("rst_release_count", int'(bus.d_out), 1);

      // Up wrap from 9
      drive(1, 0, 9);
      step();
      check_eq("up_load9", int'(bus.d_out), 9);
      drive(0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("up_wrap", int'(bus.d_out), up_exp[i]);
      end

      // Down wrap from 2
      drive(1, 1, 2);
      step();
      check_eq("dn_load2", int'(bus.d_out), 2);
      drive(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("dn_wrap", int'(bus.d_out), dn_exp[i]);
      end

      // Load beats count direction
      drive(1, 0, 5);
      step();
      check_eq("prio_load5", int'(bus.d_out), 5);
      drive(1, 1, 3);
      step();
      check_eq("prio_load_wins", int'(bus.d_out), 3);
      drive(0, 1, 3);
      step();
      check_eq("prio_then_up", int'(bus.d_out), 4);

      // Out-of-range load
      drive(1, 1, 13);
      step();
      check_eq("illegal_load13", int'(bus.d_out), 0);
      drive(0, 0, 0);
      step();
      check_eq("illegal_then_down", int'(bus.d_out), 11);
      drive(1, 0, 15);
      step();
      check_eq("illegal_load15", int'(bus.d_out), 0);

      // Randomized regression with occasional async reset pulses
      model = int'(bus.d_out);
      for (int i = 0; i < 1000; i++) begin
         ld  = ($urandom_range(0, 3) == 0);
         ud  = $urandom_range(0, 1);
         din = $urandom_range(0, 15);
         drive(ld, ud, din);
         if (rst && ($urandom_range(0, 49) == 0)) begin
            #2;
            rst = 1'b0;
            model = 0;
            #1;
            check_eq("rnd_rst_async", int'(bus.d_out), 0);
         end else if (!rst && ($urandom_range(0, 1) == 1)) begin
            rst = 1'b1;
         end
         step();
         check_eq("rnd_count", int'(bus.d_out), model);
         check_eq("rnd_range", int'(bus.d_out <= 4'd11), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
